sdf_stage_ctrl: RTL and testbench

Sequencer for one radix-2 single-delay-feedback (SDF) NTT stage: input mux, delay FIFO, butterfly, output mux, twiddle ROM and Montgomery multiplier. It tracks the sample position inside each transform frame and drives every control point of the stage from that position. Those control points are FIFO push/pop, both mux selects and the twiddle ROM address. It also provides a valid/ready stream interface, a drain (flush) sequence and output-valid alignment to the multiplier latency. One instance sits beside each stage datapath in the NTT pipeline.

---
 rtl/ntt_ctrl_pkg.sv | 24 ++
 rtl/valid_delay_line.sv | 28 ++
 rtl/sdf_stage_ctrl.sv | 159 +++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the SDF NTT stage controller: FSM state type,
// mux select encodings and the twiddle stride helper.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  // Input mux: fresh sample or butterfly difference fed back into the FIFO
  localparam logic SEL_IN_SAMPLE = 1'b0;
  localparam logic SEL_IN_DIFF   = 1'b1;

  // Output mux: delayed FIFO word or butterfly sum
  localparam logic SEL_OUT_FIFO  = 1'b0;
  localparam logic SEL_OUT_SUM   = 1'b1;

  // Twiddle address step between consecutive phase-0 samples
  function automatic int tw_stride(input int n, input int d);
    return n / (2 * d);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency 1-bit delay line used to align valid/done flags with the
// Montgomery multiplier output. Synchronous active-high reset clears all taps.
module valid_delay_line #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] taps_reg;

  // Shift the flag one tap per cycle; tap LAT-1 is the aligned output
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_reg <= '0;
    end else begin
      taps_reg[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        taps_reg[i] <= taps_reg[i-1];
      end
    end
  end

  assign dout = taps_reg[LAT-1];

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 SDF NTT stage. Tracks the sample position
// inside the transform frame and derives FIFO push/pop, mux selects and the
// twiddle ROM address from it, plus stream handshake, flush/drain sequencing
// and output-valid alignment to the multiplier latency.
// Optional macro NTT_CTRL_PERF_EN adds saturating perf_samples/perf_stalls.
module sdf_stage_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int N        = 8,
  parameter int D        = 4,
  parameter int TW_DEPTH = 8,
  parameter int MUL_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush_req,
  output logic                        push,
  output logic                        pop,
  output logic                        sel_in,
  output logic                        sel_out,
  output logic [$clog2(TW_DEPTH)-1:0] tw_addr,
  output logic                        out_valid,
  output logic                        frame_done,
  output logic                        busy
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [31:0]                 perf_samples,
  output logic [31:0]                 perf_stalls
`endif
);

  localparam int KW     = $clog2(N);
  localparam int DW     = $clog2(D);
  localparam int AW     = $clog2(TW_DEPTH);
  localparam int FW     = $clog2(D + 1);
  localparam int STRIDE = tw_stride(N, D);

  ctrl_state_t   state_reg;
  logic [KW-1:0] k_reg;
  logic          primed_reg;
  logic          flush_pend_reg;
  logic [FW-1:0] fill_reg;

  logic          phase;
  logic [KW-1:0] j_idx;
  logic          aligned;
  logic          last_drain;
  logic          align_stop;
  logic          adv;
  logic          done_raw;

  // Position decode: phase bit, offset within the half-block, 2D alignment
  assign phase      = k_reg[DW];
  assign j_idx      = k_reg & KW'(D - 1);
  assign aligned    = (k_reg & KW'(2 * D - 1)) == '0;
  assign last_drain = (j_idx == KW'(D - 1));

  // A pending (or same-cycle) flush at the 2D boundary stops intake that cycle
  assign align_stop = (state_reg == RUN) && (flush_pend_reg || flush_req) && aligned;
  assign in_ready   = (state_reg != FLUSH) && !align_stop;
  assign adv        = (in_valid && in_ready) || (state_reg == FLUSH);

  assign push     = adv;
  assign pop      = adv && (primed_reg || phase);
  assign sel_in   = phase ? SEL_IN_DIFF : SEL_IN_SAMPLE;
  assign sel_out  = phase ? SEL_OUT_SUM : SEL_OUT_FIFO;
  assign tw_addr  = phase ? '0 : AW'(j_idx) * AW'(STRIDE);
  assign done_raw = (state_reg == FLUSH) && last_drain;
  assign busy     = (state_reg != IDLE) || (fill_reg != '0);

  // Position counter and stage FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      primed_reg     <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      if (adv) begin
        k_reg <= k_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (adv && phase) begin
            primed_reg <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (flush_req) begin
            flush_pend_reg <= 1'b1;
          end
          if (align_stop) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (last_drain) begin
            k_reg          <= '0;
            primed_reg     <= 1'b0;
            flush_pend_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // FIFO occupancy for busy; drain-cycle writes are filler, so the delay
  // line is treated as empty once the final difference has left it
  always_ff @(posedge clk) begin
    if (rst || done_raw) begin
      fill_reg <= '0;
    end else if (push && !pop && (fill_reg != FW'(D))) begin
      fill_reg <= fill_reg + 1'b1;
    end
  end

  valid_delay_line #(.LAT(MUL_LAT)) u_valid_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (pop),
    .dout (out_valid)
  );

  valid_delay_line #(.LAT(MUL_LAT)) u_done_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (done_raw),
    .dout (frame_done)
  );

`ifdef NTT_CTRL_PERF_EN
  logic [31:0] perf_samples_reg;
  logic [31:0] perf_stalls_reg;

  // Saturating activity counters: delivered results and starved RUN cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_samples_reg <= '0;
      perf_stalls_reg  <= '0;
    end else begin
      if (out_valid && (perf_samples_reg != '1)) begin
        perf_samples_reg <= perf_samples_reg + 1'b1;
      end
      if ((state_reg == RUN) && !in_valid && (perf_stalls_reg != '1)) begin
        perf_stalls_reg <= perf_stalls_reg + 1'b1;
      end
    end
  end

  assign perf_samples = perf_samples_reg;
  assign perf_stalls  = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl (N=8, D=4, MUL_LAT=2). The reference
// model counts accepted samples since the frame start and derives every
// expected control value from that count with plain arithmetic.
module tb_sdf_stage_ctrl;

  localparam int N        = 8;
  localparam int D        = 4;
  localparam int TW_DEPTH = 8;
  localparam int MUL_LAT  = 2;
  localparam int AW       = $clog2(TW_DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush_req = 1'b0;
  logic          in_ready, push, pop, sel_in, sel_out;
  logic          out_valid, frame_done, busy;
  logic [AW-1:0] tw_addr;
`ifdef NTT_CTRL_PERF_EN
  logic [31:0]   perf_samples, perf_stalls;
  int            m_samples, m_stalls;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_count;   // advances since reset / last completed flush
  int            m_drain;   // drain cycles still to run
  bit            m_pend;
  bit            v_q[$];
  bit            d_q[$];
  // Expected values for the current cycle
  bit            e_in_ready, e_push, e_pop, e_sel, e_out_valid, e_frame_done;
  bit            e_busy, e_stop, e_adv, e_running, cur_fr;
  logic [AW-1:0] e_tw;

  sdf_stage_ctrl #(
    .N(N), .D(D), .TW_DEPTH(TW_DEPTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush_req  (flush_req),
    .push       (push),
    .pop        (pop),
    .sel_in     (sel_in),
    .sel_out    (sel_out),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef NTT_CTRL_PERF_EN
    ,
    .perf_samples (perf_samples),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_count = 0;
    m_drain = 0;
    m_pend  = 1'b0;
    v_q.delete();
    d_q.delete();
    for (int i = 0; i < MUL_LAT; i++) begin
      v_q.push_back(1'b0);
      d_q.push_back(1'b0);
    end
`ifdef NTT_CTRL_PERF_EN
    m_samples = 0;
    m_stalls  = 0;
`endif
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    flush_req = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs and compute the expected outputs
  task automatic cycle_drive(input bit iv, input bit fr);
    int pos, j;
    bit ph;
    @(negedge clk);
    in_valid  = iv;
    flush_req = fr;
    cur_fr    = fr;
    #1;
    pos       = m_count % N;
    ph        = ((pos / D) % 2) == 1;
    j         = pos % D;
    e_running = (m_drain == 0) && (m_count > D);
    e_stop    = e_running && (m_pend || fr) && ((pos % (2 * D)) == 0);
    e_in_ready = (m_drain == 0) && !e_stop;
    e_adv     = (iv && e_in_ready) || (m_drain > 0);
    e_push    = e_adv;
    e_pop     = e_adv && (m_count >= D);
    e_sel     = ph;
    e_tw      = ph ? '0 : AW'(j * (N / (2 * D)));
    e_out_valid  = v_q[0];
    e_frame_done = d_q[0];
    e_busy    = (m_count > 0) || (m_drain > 0);
  endtask

  // Advance the model past the coming rising edge
  task automatic cycle_commit();
    if (e_adv) begin
      $display("txn k=%0d push=%0b pop=%0b sel=%0b tw=%0d drain=%0b",
               m_count % N, e_push, e_pop, e_sel, e_tw, (m_drain > 0));
    end
`ifdef NTT_CTRL_PERF_EN
    if (e_out_valid) m_samples++;
    if (e_running && !in_valid) m_stalls++;
`endif
    v_q.push_back(e_pop);
    v_q.delete(0);
    d_q.push_back(m_drain == 1);
    d_q.delete(0);
    if (e_adv) m_count++;
    if (e_running && cur_fr) m_pend = 1'b1;
    if (e_stop) begin
      m_drain = D;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin
        m_count = 0;
        m_pend  = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset(3);
    cycle_drive(1'b0, 1'b0);
    total++;
    if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=10000000",
               {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy});
    end
    total++;
    if (tw_addr !== '0) begin
      bad++;
      $display("FAIL reset_tw got=%0d want=0", tw_addr);
    end
    cycle_commit();
  endtask

  task automatic test_stream();
    do_reset(2);
    for (int i = 0; i < 2 * N; i++) begin
      cycle_drive(1'b1, 1'b0);
      total++;
      if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr} !==
          {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw}) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%b want=%b", i,
                 {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr},
                 {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw});
      end
      if (i == 5 || i == 6) begin
        total++;
        if (out_valid !== (i == 6)) begin
          bad++;
          $display("FAIL stream_first_valid cyc=%0d got=%b want=%b", i, out_valid, (i == 6));
        end
      end
      cycle_commit();
    end
  endtask

  task automatic test_gaps();
    bit iv;
    do_reset(2);
    for (int i = 0; i < 48; i++) begin
      iv = (i < 24) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      cycle_drive(iv, 1'b0);
      total++;
      if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr} !==
          {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw}) begin
        bad++;
        $display("FAIL gaps cyc=%0d iv=%0b got=%b want=%b", i, iv,
                 {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr},
                 {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw});
      end
      cycle_commit();
    end
  endtask

  task automatic test_flush();
    bit started = 1'b0;
    bit fd_seen = 1'b0;
    int after   = 0;
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      cycle_drive(!started, (i == N + 2));
      if (e_stop) started = 1'b1;
      total++;
      if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr} !==
          {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw}) begin
        bad++;
        $display("FAIL flush cyc=%0d got=%b want=%b", i,
                 {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr},
                 {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw});
      end
      if (frame_done === 1'b1) fd_seen = 1'b1;
      cycle_commit();
      if (fd_seen) after++;
      if (after == 3) break;
    end
    total++;
    if (!fd_seen) begin
      bad++;
      $display("FAIL flush_done_timeout got=0 want=1");
    end
    cycle_drive(1'b0, 1'b0);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle busy=%b in_ready=%b want busy=0 in_ready=1", busy, in_ready);
    end
    cycle_commit();
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 1'b0);
      cycle_commit();
    end
    do_reset(1);
    cycle_drive(1'b0, 1'b0);
    total++;
    if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr} !==
        {8'b1000_0000, AW'(0)}) begin
      bad++;
      $display("FAIL midreset_state got=%b want=%b",
               {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr},
               {8'b1000_0000, AW'(0)});
    end
    cycle_commit();
    cycle_drive(1'b1, 1'b0);
    total++;
    if (push !== 1'b1 || pop !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_first push=%b pop=%b ov=%b want 1 0 0", push, pop, out_valid);
    end
    cycle_commit();
  endtask

  task automatic test_idle_flush();
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      cycle_drive((i >= 8), 1'b1);
      total++;
      if (in_ready !== 1'b1 || frame_done !== 1'b0 || push !== e_push || busy !== e_busy) begin
        bad++;
        $display("FAIL idle_flush cyc=%0d in_ready=%b fd=%b push=%b busy=%b want 1 0 %b %b",
                 i, in_ready, frame_done, push, busy, e_push, e_busy);
      end
      cycle_commit();
    end
  endtask

  task automatic test_random();
    bit iv, fr;
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 15) == 0);
      cycle_drive(iv, fr);
      total++;
      if ({in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr} !==
          {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw}) begin
        bad++;
        $display("FAIL random cyc=%0d iv=%0b fr=%0b got=%b want=%b", i, iv, fr,
                 {in_ready, push, pop, sel_in, sel_out, out_valid, frame_done, busy, tw_addr},
                 {e_in_ready, e_push, e_pop, e_sel, e_sel, e_out_valid, e_frame_done, e_busy, e_tw});
      end
      cycle_commit();
    end
`ifdef NTT_CTRL_PERF_EN
    #1;
    total++;
    if (perf_samples !== 32'(m_samples) || perf_stalls !== 32'(m_stalls)) begin
      bad++;
      $display("FAIL perf samples=%0d stalls=%0d want %0d %0d",
               perf_samples, perf_stalls, m_samples, m_stalls);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_gaps();
    test_flush();
    test_mid_reset();
    test_idle_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
